// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    // Divide/remainder operations all have funct3[2] set.
    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic              is_div,
    input  logic [XLEN-1:0]   opnd,
    input  logic [2*XLEN-1:0] acc_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        acc_o   = acc_i;
        sum     = (XLEN+1)'(0);
        shifted = (XLEN+1)'(0);
        diff    = (XLEN+1)'(0);
        if (is_div) begin
            shifted = acc_i[2*XLEN-1:XLEN-1];
            diff    = shifted - {1'b0, opnd};
            if (diff[XLEN]) begin
                acc_o = {shifted[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
            end else begin
                acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
            end
        end else begin
            sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd} : (XLEN+1)'(0));
            acc_o = {sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshake, rd tag and flush.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned STEP  = 1,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  op1,
    input  logic [XLEN-1:0]  op2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned N_ITER = XLEN / STEP;
    localparam int unsigned CNT_W  = $clog2(N_ITER + 1);
    localparam int unsigned DW     = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [XLEN-1:0]  opnd_q, opnd_d;
    logic [2:0]       f3_q, f3_d;
    logic             neg_q, neg_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic            op1_signed, op2_signed, neg1, neg2;
    logic [XLEN-1:0] abs1, abs2;
    logic            is_div, div_zero, div_ovf;
    logic [XLEN-1:0] special_res;
    logic [DW-1:0]   prod_fix;
    logic [XLEN-1:0] rem_raw;
    logic [XLEN-1:0] fix_res;

    logic [DW-1:0] chain [STEP+1];

    assign chain[0] = acc_q;

    for (genvar g = 0; g < STEP; g++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .is_div (f3_is_div(f3_q)),
            .opnd   (opnd_q),
            .acc_i  (chain[g]),
            .acc_o  (chain[g+1])
        );
    end

    // Operand magnitudes, result sign and the short-circuit cases, decoded at accept.
    always_comb begin
        op1_signed  = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                      (funct3 == F3_DIV)  || (funct3 == F3_REM);
        op2_signed  = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        neg1        = op1_signed && op1[XLEN-1];
        neg2        = op2_signed && op2[XLEN-1];
        abs1        = neg1 ? XLEN'(0) - op1 : op1;
        abs2        = neg2 ? XLEN'(0) - op2 : op2;
        is_div      = f3_is_div(funct3);
        div_zero    = is_div && (op2 == XLEN'(0));
        div_ovf     = is_div && op2_signed && (op1 == MIN_INT) && (op2 == {XLEN{1'b1}});
        special_res = {XLEN{1'b1}};
        if (div_zero) begin
            special_res = funct3[1] ? op1 : {XLEN{1'b1}};
        end else if (div_ovf) begin
            special_res = funct3[1] ? XLEN'(0) : MIN_INT;
        end
    end

    // Sign correction and half/quotient/remainder selection.
    always_comb begin
        prod_fix = neg_q ? DW'(0) - acc_q : acc_q;
        rem_raw  = acc_q[DW-1:XLEN];
        case (f3_q)
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[DW-1:XLEN];
            F3_REM, F3_REMU:              fix_res = neg_q ? XLEN'(0) - rem_raw : rem_raw;
            default:                      fix_res = prod_fix[XLEN-1:0];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        result_d = result_q;
        tag_d    = tag_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q && !flush) begin
                    f3_d  = funct3;
                    tag_d = in_tag;
                    neg_d = (funct3 == F3_REM) ? neg1 : (neg1 ^ neg2);
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else begin
                        acc_d   = is_div ? {XLEN'(0), abs1} : {XLEN'(0), abs2};
                        opnd_d  = is_div ? abs2 : abs1;
                        cnt_d   = CNT_W'(N_ITER);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = chain[STEP];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = fix_res;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush outranks out_ready and drops any request arriving with it.
        if (flush) begin
            state_d = IDLE;
        end

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_W'(0);
            acc_q       <= DW'(0);
            opnd_q      <= XLEN'(0);
            f3_q        <= 3'b000;
            neg_q       <= 1'b0;
            result_q    <= XLEN'(0);
            tag_q       <= TAG_W'(0);
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            f3_q        <= f3_d;
            neg_q       <= neg_d;
            result_q    <= result_d;
            tag_q       <= tag_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases, flush/reset, backpressure, random ops.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    parameter int unsigned STEP_P = 1;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned NRAND = 1200;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  op1, op2;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    muldiv_unit #(.XLEN(XLEN), .STEP(STEP_P), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .op1       (op1),
        .op2       (op2),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
        longint      acc_cyc;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    exp_t   exp_q[$];
    vec_t   vecs[$];
    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;
    bit     bp_hold = 1'b0;
    bit     prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference behaviour from plain signed/unsigned 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sbv, ps;
        logic [63:0] pu;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        pu  = 64'(a) * 64'(b);
        case (f3)
            F3_MUL:    return pu[31:0];
            F3_MULH:   begin ps = sa * sbv; return ps[63:32]; end
            F3_MULHSU: begin ps = sa * longint'({32'b0, b}); return ps[63:32]; end
            F3_MULHU:  return pu[63:32];
            F3_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                ps = sa / sbv; return ps[31:0];
            end
            F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM:    begin
                if (b == 0) return a;
                ps = sa % sbv; return ps[31:0];
            end
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = f3[2] && ((b == 0) ||
                  (((f3 == F3_DIV) || (f3 == F3_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
        return special ? 1 : int'(XLEN / STEP_P) + 2;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            4:       return 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp_res, input bit push);
        int n = 0;
        while (!in_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL issue_wait: in_ready stayed 0 for %0d cycles", n);
            return;
        end
        in_valid = 1'b1; funct3 = f3; op1 = a; op2 = b; in_tag = tag;
        @(posedge clk); #1;
        if (push) exp_q.push_back('{res: exp_res, tag: tag, lat: lat_of(f3, a, b), acc_cyc: cyc});
        in_valid = 1'b0;
        funct3 = 3'($urandom); op1 = $urandom; op2 = $urandom; in_tag = 5'($urandom);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every cycle out_valid is high the held response must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: out_valid with result %h and nothing outstanding", result);
                end else begin
                    if (!prev_valid) check("latency", 64'(cyc - exp_q[0].acc_cyc + 1), 64'(exp_q[0].lat));
                    check("result", 64'(result), 64'(exp_q[0].res));
                    check("out_tag", 64'(out_tag), 64'(exp_q[0].tag));
                    check("in_ready_in_done", 64'(in_ready), 64'(0));
                    if (out_ready && !flush) void'(exp_q.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        logic [31:0] a, b;
        logic [2:0]  f3;
        bit          drained;

        reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
        funct3 = 3'b000; op1 = 32'h0; op2 = 32'h0; in_tag = 5'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_out_tag", 64'(out_tag), 64'(0));

        // Flush sampled in CALC cycle 5.
        issue(F3_MUL, 32'd123, 32'd456, 5'd3, 32'h0, 1'b0);
        check("calc_busy", 64'(busy), 64'(1));
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'(1));
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_busy", 64'(busy), 64'(0));

        // Reset sampled in CALC cycle 12.
        issue(F3_DIVU, 32'd1000, 32'd3, 5'd9, 32'h0, 1'b0);
        repeat (11) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("rst2_in_ready", 64'(in_ready), 64'(1));
        check("rst2_busy", 64'(busy), 64'(0));
        check("rst2_result", 64'(result), 64'(0));
        check("rst2_out_tag", 64'(out_tag), 64'(0));

        // Request coinciding with flush in IDLE is dropped.
        in_valid = 1'b1; flush = 1'b1; funct3 = F3_DIV; op1 = 32'd5; op2 = 32'd0; in_tag = 5'd7;
        @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
        check("drop_in_ready", 64'(in_ready), 64'(1));
        check("drop_busy", 64'(busy), 64'(0));

        vecs.push_back('{F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
        vecs.push_back('{F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000});
        vecs.push_back('{F3_MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000});
        vecs.push_back('{F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF});
        vecs.push_back('{F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
        vecs.push_back('{F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
        vecs.push_back('{F3_DIVU,   32'd100,        32'd7,         32'd14});
        vecs.push_back('{F3_REMU,   32'd100,        32'd7,         32'd2});
        vecs.push_back('{F3_DIV,    32'd1234,       32'd0,         32'hFFFF_FFFF});
        vecs.push_back('{F3_REM,    32'd1234,       32'd0,         32'd1234});
        vecs.push_back('{F3_DIVU,   32'hDEAD_BEEF,  32'd0,         32'hFFFF_FFFF});
        vecs.push_back('{F3_REMU,   32'hDEAD_BEEF,  32'd0,         32'hDEAD_BEEF});
        vecs.push_back('{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0});
        foreach (vecs[i]) issue(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].r, 1'b1);

        // Hold the consumer off for 10 cycles once the result is up.
        repeat (80) @(posedge clk);
        #1 bp_hold = 1'b1;
        issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 32'hFFFF_FFFE, 1'b1);
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        check("bp_out_valid_held", 64'(out_valid), 64'(1));
        check("bp_in_ready_low", 64'(in_ready), 64'(0));
        check("bp_result_held", 64'(result), 64'(32'hFFFF_FFFE));
        bp_hold = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < int'(NRAND); i++) begin
            f3 = 3'($urandom);
            a  = rnd_op();
            b  = rnd_op();
            issue(f3, a, b, 5'($urandom), model(f3, a, b), 1'b1);
        end

        drained = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        if (!drained) begin
            total++; bad++;
            $display("FAIL drain: %0d responses never arrived", exp_q.size());
        end
        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
